// File: rtl/wb_stage_pkg.sv
// Shared definitions for the write-back stage: word-size codes, FSM states
// and default widths.
package wb_stage_pkg;

  localparam int NB_DATA_DEF = 32;
  localparam int NB_ADDR_DEF = 32;
  localparam int NB_REG_DEF  = 5;
  localparam int NB_CNT_DEF  = 32;

  // 2'b10 is not a legal code from MEM; it is handled as a full word.
  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b11
  } word_size_t;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } wb_state_t;

endpackage

// File: rtl/wb_stage_load_formatter.sv
// Combinational sub-word load extraction and sign/zero extension.
// Lanes are little-endian: address byte k lives in bits [8k+7:8k].
module wb_stage_load_formatter
  import wb_stage_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF
) (
  input  logic [NB_DATA-1:0] raw_word,
  input  logic [1:0]         addr,
  input  logic [1:0]         size,
  input  logic               is_unsigned,
  output logic [NB_DATA-1:0] ext_word
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  // Pick the addressed byte and halfword lanes; halfword ignores addr[0].
  always_comb begin
    lane_byte = raw_word[8*addr +: 8];
    lane_half = addr[1] ? raw_word[31:16] : raw_word[15:0];
  end

  // Extend the selected lane according to access size and signedness.
  always_comb begin
    ext_word = raw_word;
    case (size)
      SIZE_BYTE: ext_word = {{(NB_DATA-8){lane_byte[7] & ~is_unsigned}}, lane_byte};
      SIZE_HALF: ext_word = {{(NB_DATA-16){lane_half[15] & ~is_unsigned}}, lane_half};
      default:   ext_word = raw_word;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MIPS write-back stage: MEM/WB pipeline register, load formatting,
// register-file write port, HALT retirement FSM and retired counter.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_RUN    | normal operation; latched instructions write and count
// ST_HALTED | HALT has retired; writes and counting frozen until reset
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_ADDR = NB_ADDR_DEF,
  parameter int NB_REG  = NB_REG_DEF,
  parameter int NB_CNT  = NB_CNT_DEF
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_WB_enable,
  input  logic               i_WB_flush,
  input  logic               i_WB_valid,
  input  logic               i_WB_reg_write,
  input  logic               i_WB_mem_to_reg,
  input  logic [1:0]         i_WB_word_size,
  input  logic               i_WB_unsigned,
  input  logic               i_WB_halt,
  input  logic [NB_DATA-1:0] i_WB_mem_data,
  input  logic [NB_ADDR-1:0] i_WB_alu_result,
  input  logic [NB_REG-1:0]  i_WB_selected_reg,
  output logic [NB_DATA-1:0] o_WB_write_data,
  output logic [NB_REG-1:0]  o_WB_selected_reg,
  output logic               o_WB_reg_write,
  output logic               o_WB_halt,
  output logic [NB_CNT-1:0]  o_WB_retired
);

  localparam logic [NB_CNT-1:0] CNT_MAX = {NB_CNT{1'b1}};

  logic               r_valid;
  logic               r_reg_write;
  logic               r_mem_to_reg;
  logic [1:0]         r_word_size;
  logic               r_unsigned;
  logic               r_halt;
  logic [NB_DATA-1:0] r_mem_data;
  logic [NB_ADDR-1:0] r_alu_result;
  logic [NB_REG-1:0]  r_selected_reg;
  // Set only on the edge that loads the register, so a stalled slot is
  // counted once rather than once per held cycle.
  logic               r_fresh;

  wb_state_t          state;
  wb_state_t          state_next;
  logic               in_run;
  logic               halted;

  logic [NB_CNT-1:0]  retired;
  logic [NB_DATA-1:0] fmt_data;

  // MEM/WB pipeline register: reset > flush > stall > load.
  always_ff @(posedge i_clock) begin
    if (!i_reset || i_WB_flush) begin
      r_valid        <= 1'b0;
      r_reg_write    <= 1'b0;
      r_mem_to_reg   <= 1'b0;
      r_word_size    <= 2'b00;
      r_unsigned     <= 1'b0;
      r_halt         <= 1'b0;
      r_mem_data     <= '0;
      r_alu_result   <= '0;
      r_selected_reg <= '0;
      r_fresh        <= 1'b0;
    end else if (i_WB_enable) begin
      r_valid        <= i_WB_valid;
      r_reg_write    <= i_WB_reg_write;
      r_mem_to_reg   <= i_WB_mem_to_reg;
      r_word_size    <= i_WB_word_size;
      r_unsigned     <= i_WB_unsigned;
      r_halt         <= i_WB_halt;
      r_mem_data     <= i_WB_mem_data;
      r_alu_result   <= i_WB_alu_result;
      r_selected_reg <= i_WB_selected_reg;
      r_fresh        <= 1'b1;
    end else begin
      r_fresh        <= 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge i_clock) begin
    if (!i_reset) state <= ST_RUN;
    else          state <= state_next;
  end

  // FSM next state: a valid HALT sitting in the register retires it.
  always_comb begin
    state_next = state;
    case (state)
      ST_RUN:    if (r_valid && r_halt) state_next = ST_HALTED;
      ST_HALTED: state_next = ST_HALTED;
      default:   state_next = ST_RUN;
    endcase
  end

  // FSM outputs.
  always_comb begin
    in_run = 1'b0;
    halted = 1'b0;
    case (state)
      ST_RUN:    in_run = 1'b1;
      ST_HALTED: halted = 1'b1;
      default:   in_run = 1'b0;
    endcase
  end

  // Retired counter: one count per freshly loaded valid slot, saturating.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      retired <= '0;
    end else if (r_fresh && r_valid && in_run && (retired != CNT_MAX)) begin
      retired <= retired + 1'b1;
    end
  end

  wb_stage_load_formatter #(
    .NB_DATA (NB_DATA)
  ) u_load_formatter (
    .raw_word    (r_mem_data),
    .addr        (r_alu_result[1:0]),
    .size        (r_word_size),
    .is_unsigned (r_unsigned),
    .ext_word    (fmt_data)
  );

  // Write-back port; data is shown even when the write is suppressed.
  always_comb begin
    o_WB_write_data   = r_mem_to_reg ? fmt_data : NB_DATA'(r_alu_result);
    o_WB_selected_reg = r_selected_reg;
    o_WB_reg_write    = r_valid && r_reg_write && !r_halt &&
                        (r_selected_reg != '0) && in_run;
    o_WB_halt         = halted;
    o_WB_retired      = retired;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
Write-back stage of the 5-stage MIPS pipeline, directly downstream of MEM_stage.
- Latches the MEM/WB pipeline register from MEM_stage outputs (memory data, ALU result, selected register, control flags).
- Formats sub-word loads, selects the write-back value and drives the register-file write port plus forwarding-unit taps.
- Tracks HALT retirement and counts retired instructions for the debug unit.

Parameters:
NB_DATA, 32, data/register width
NB_ADDR, 32, ALU result / address width
NB_REG, 5, register index width
NB_CNT, 32, retired-instruction counter width

Ports:
i_clock  in  1  system clock, all state on rising edge
i_reset  in  1  synchronous, active-low reset
i_WB_enable  in  1  1 = capture new MEM/WB contents, 0 = stall/hold
i_WB_flush  in  1  1 = load a bubble on this edge
i_WB_valid  in  1  incoming slot holds a real instruction
i_WB_reg_write  in  1  instruction writes the register file
i_WB_mem_to_reg  in  1  1 = write memory data, 0 = write ALU result
i_WB_word_size  in  2  00 byte, 01 halfword, 11 word (10 treated as word)
i_WB_unsigned  in  1  1 = zero-extend sub-word load, 0 = sign-extend
i_WB_halt  in  1  incoming instruction is HALT
i_WB_mem_data  in  NB_DATA  raw word from data memory
i_WB_alu_result  in  NB_ADDR  ALU result / effective address
i_WB_selected_reg  in  NB_REG  destination register
o_WB_write_data  out  NB_DATA  value to register file
o_WB_selected_reg  out  NB_REG  destination register to register file and forwarding unit
o_WB_reg_write  out  1  register-file write enable
o_WB_halt  out  1  sticky: HALT has retired
o_WB_retired  out  NB_CNT  retired instruction count

Behaviour:
- Reset (i_reset==0 at an edge): pipeline register cleared (valid=0, all fields 0), FSM=RUN, counter=0.
  - Outputs after reset: write_data 0, selected_reg 0, reg_write 0, halt 0, retired 0.
- Latency: inputs captured on edge N drive outputs during cycle N+1. Outputs are combinational from the latched register only; no input-to-output combinational path.
- Capture priority on each edge: reset > flush > stall > load.
  - Flush: valid=0 and control fields cleared; data fields don't-care.
  - Stall (enable=0, flush=0): register holds, counter does not increment again.
  - Load: all fields captured.
- Load formatting, applied when mem_to_reg=1. Lane = alu_result[1:0], little-endian.
  - Byte: lane 0..3 selects bits [8k+7:8k].
  - Halfword: alu_result[1] selects [15:0] or [31:16]; alu_result[0] ignored.
  - Word: passthrough; no alignment check.
  - Extension per unsigned flag.
- Write data: mem_to_reg ? formatted mem data : alu_result.
- Write enable: o_WB_reg_write = valid & reg_write & (selected_reg!=0) & (state==RUN).
  - Writes to r0 are always suppressed.
  - o_WB_write_data still shows the computed value even when the enable is suppressed.
- FSM RUN/HALTED:
  - RUN -> HALTED on the edge after a valid halt instruction is latched, i.e. the HALT is in the register during RUN.
  - HALTED is absorbing; only reset leaves it.
  - HALT itself never writes the register file.
  - o_WB_halt = (state==HALTED).
- Counter: increments by 1 in the cycle each valid latched instruction (HALT included) is first presented in RUN.
  - Counted once per capture, never per stalled cycle.
  - Saturates at 2^NB_CNT-1; no wrap.
  - Frozen in HALTED.
- Simultaneous events:
  - flush with halt=1 on the input: bubble wins, no halt.
  - Reset during HALTED or mid-stall: full reset.
  - Instructions arriving after HALTED are ignored: no write, no count.

Decomposition:
- Shared package: word-size encodings (BYTE=2'b00, HALF=2'b01, WORD=2'b11), FSM state encoding (RUN, HALTED), width defaults.
- One natural sub-module: load_formatter, purely combinational. Inputs: raw word, addr[1:0], size, unsigned. Output: extended word.
- The remaining RTL (pipeline register, FSM, counter) stays in wb_stage.

Test Plan:
- Reset: hold i_reset=0 two edges with valid inputs -> all outputs 0, retired=0; release -> first captured instruction appears one cycle later.
- Load formatting: mem_data=32'h80F07F12, mem_to_reg=1.
  - Byte signed, addr 3 -> FFFFFF80.
  - Byte unsigned, addr 1 -> 0000007F.
  - Half signed, addr 2 -> FFFF80F0.
  - Half unsigned, addr 3 -> 000080F0.
  - Word -> 80F07F12.
- ALU path / r0: mem_to_reg=0, alu_result=32'h4, reg=5 -> write_data 4, reg_write 1. Same with reg=0 -> reg_write 0.
- Stall/flush: stall 3 cycles -> outputs held, retired +1 only. Flush with valid load -> reg_write 0, retired unchanged. Flush+enable=0 together -> bubble.
- Halt: valid HALT to reg 7 -> no write, halt=1 next cycle, retired +1. Following valid writes -> reg_write 0, retired frozen. Reset -> halt=0.
- Saturation: NB_CNT=4, stream 20 valid instructions -> retired stops at 15.
